// File: rtl/mem_pkg.sv
// Shared types and constants for the bmem line adapter.
//   line_t          : one 256-bit cacheline
//   beat_t          : one 64-bit bmem data beat
//   adapter_state_e : adapter sequencing states
//   LINE_OFFSET_W   : byte-offset bits within a line (ignored/zeroed on addresses)
package mem_pkg;

    localparam int unsigned LINE_OFFSET_W = 5;

    typedef logic [255:0] line_t;
    typedef logic [63:0]  beat_t;

    typedef enum logic [2:0] {
        StIdle,
        StRdCmd,
        StRdWait,
        StWrBurst,
        StResp
    } adapter_state_e;

endpackage

// File: rtl/line_deser.sv
// Read-line deserialiser: BEATS slots of BEAT_W bits, one slot written per
// enabled cycle at the given index; the full line is presented continuously.
// Ports:
//   clk, rst : clock, synchronous active-low reset (clears all slots)
//   we       : write enable for the selected slot
//   slot     : slot index to write
//   beat     : beat data to store
//   line     : concatenated slots, slot 0 in the least significant bits
module line_deser
    import mem_pkg::*;
#(
    parameter int unsigned BEAT_W = $bits(beat_t),
    parameter int unsigned BEATS  = 4,
    localparam int unsigned SLOT_W = $clog2(BEATS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [SLOT_W-1:0]        slot,
    input  logic [BEAT_W-1:0]        beat,
    output logic [BEAT_W*BEATS-1:0]  line
);

    logic [BEATS-1:0][BEAT_W-1:0] slots_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            slots_q <= '0;
        end else if (we) begin
            slots_q[slot] <= beat;
        end
    end

    assign line = slots_q;

endmodule

// File: rtl/bmem_line_adapter.sv
// Line-to-burst adapter between the memory arbiter and banked main memory.
// Accepts one line read/write at a time, serialises writes into BEATS bmem
// beats, collects BEATS matching read beats into a line and returns a
// one-cycle response carrying the line address.
// Ports:
//   clk, rst                 : clock, synchronous active-low reset
//   line_addr/read/write     : line request (write wins over read)
//   line_wdata               : write line, beat 0 in the low bits
//   line_ready               : high only when idle; request accepted on ready & req
//   line_rdata/raddr/resp    : one-cycle completion with assembled line + address
//   bmem_addr/read/write     : bmem command/beat strobe at the latched line address
//   bmem_wdata               : current write beat
//   bmem_ready               : bmem accepts command/beat this cycle
//   bmem_raddr/rdata/rvalid  : returning read beat with its address tag
module bmem_line_adapter
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned BEAT_W = 64,
    parameter int unsigned BEATS  = 4,
    localparam int unsigned LINE_W = BEAT_W * BEATS,
    localparam int unsigned SLOT_W = $clog2(BEATS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] line_addr,
    input  logic              line_read,
    input  logic              line_write,
    input  logic [LINE_W-1:0] line_wdata,
    output logic              line_ready,
    output logic [LINE_W-1:0] line_rdata,
    output logic [ADDR_W-1:0] line_raddr,
    output logic              line_resp,
    output logic [ADDR_W-1:0] bmem_addr,
    output logic              bmem_read,
    output logic              bmem_write,
    output logic [BEAT_W-1:0] bmem_wdata,
    input  logic              bmem_ready,
    input  logic [ADDR_W-1:0] bmem_raddr,
    input  logic [BEAT_W-1:0] bmem_rdata,
    input  logic              bmem_rvalid
);

    adapter_state_e               state_q, state_d;
    logic [SLOT_W-1:0]            beat_cnt_q, beat_cnt_d;
    logic [ADDR_W-1:0]            addr_q, addr_d;
    logic [BEATS-1:0][BEAT_W-1:0] wdata_q, wdata_d;
    // Registered copy of "next state is idle" so ready stays low while in reset.
    logic                         ready_q;

    logic accept;
    logic tag_match;
    logic last_beat;
    logic beat_we;

    // Offset bits of both addresses carry no meaning at line granularity.
    logic unused_offsets;
    assign unused_offsets = ^{line_addr[LINE_OFFSET_W-1:0], bmem_raddr[LINE_OFFSET_W-1:0]};

    assign accept    = ready_q & (line_read | line_write);
    assign tag_match = bmem_raddr[ADDR_W-1:LINE_OFFSET_W] == addr_q[ADDR_W-1:LINE_OFFSET_W];
    assign last_beat = beat_cnt_q == SLOT_W'(BEATS - 1);

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        beat_we    = 1'b0;

        case (state_q)
            StIdle: begin
                beat_cnt_d = '0;
                if (accept) begin
                    addr_d  = {line_addr[ADDR_W-1:LINE_OFFSET_W], {LINE_OFFSET_W{1'b0}}};
                    wdata_d = line_wdata;
                    state_d = line_write ? StWrBurst : StRdCmd;
                end
            end
            StRdCmd: begin
                if (bmem_ready) begin
                    state_d = StRdWait;
                end
            end
            StRdWait: begin
                // Beats tagged for another line (e.g. from an aborted read) are dropped.
                if (bmem_rvalid && tag_match) begin
                    beat_we    = 1'b1;
                    beat_cnt_d = beat_cnt_q + SLOT_W'(1);
                    if (last_beat) begin
                        state_d = StResp;
                    end
                end
            end
            StWrBurst: begin
                if (bmem_ready) begin
                    beat_cnt_d = beat_cnt_q + SLOT_W'(1);
                    if (last_beat) begin
                        state_d = StResp;
                    end
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            beat_cnt_q <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            ready_q    <= (state_d == StIdle);
        end
    end

    line_deser #(
        .BEAT_W (BEAT_W),
        .BEATS  (BEATS)
    ) u_line_deser (
        .clk  (clk),
        .rst  (rst),
        .we   (beat_we),
        .slot (beat_cnt_q),
        .beat (bmem_rdata),
        .line (line_rdata)
    );

    assign line_ready = ready_q;
    assign line_resp  = (state_q == StResp);
    assign line_raddr = addr_q;
    assign bmem_read  = (state_q == StRdCmd);
    assign bmem_write = (state_q == StWrBurst);
    assign bmem_addr  = addr_q;
    assign bmem_wdata = bmem_write ? wdata_q[beat_cnt_q] : '0;

endmodule

// File: tb/tb_bmem_line_adapter.sv
// Directed self-checking bench for bmem_line_adapter. Inputs are driven and
// outputs sampled on the falling clock edge.
module tb_bmem_line_adapter;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  line_addr;
    logic         line_read;
    logic         line_write;
    logic [255:0] line_wdata;
    logic         line_ready;
    logic [255:0] line_rdata;
    logic [31:0]  line_raddr;
    logic         line_resp;
    logic [31:0]  bmem_addr;
    logic         bmem_read;
    logic         bmem_write;
    logic [63:0]  bmem_wdata;
    logic         bmem_ready;
    logic [31:0]  bmem_raddr;
    logic [63:0]  bmem_rdata;
    logic         bmem_rvalid;

    int n_cmp = 0;
    int n_err = 0;
    logic [255:0] last_line;

    always #5 clk = ~clk;

    bmem_line_adapter dut (
        .clk         (clk),
        .rst         (rst),
        .line_addr   (line_addr),
        .line_read   (line_read),
        .line_write  (line_write),
        .line_wdata  (line_wdata),
        .line_ready  (line_ready),
        .line_rdata  (line_rdata),
        .line_raddr  (line_raddr),
        .line_resp   (line_resp),
        .bmem_addr   (bmem_addr),
        .bmem_read   (bmem_read),
        .bmem_write  (bmem_write),
        .bmem_wdata  (bmem_wdata),
        .bmem_ready  (bmem_ready),
        .bmem_raddr  (bmem_raddr),
        .bmem_rdata  (bmem_rdata),
        .bmem_rvalid (bmem_rvalid)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; line_addr = '0; line_read = 1'b0; line_write = 1'b0; line_wdata = '0;
        bmem_ready = 1'b1; bmem_raddr = '0; bmem_rdata = '0; bmem_rvalid = 1'b0;
        repeat (3) step();
        if (line_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b, expected 0", line_ready); end n_cmp++;
        if (line_resp !== 1'b0) begin n_err++; $display("FAIL rst_resp: got %b, expected 0", line_resp); end n_cmp++;
        if (line_rdata !== '0) begin n_err++; $display("FAIL rst_rdata: got %h, expected 0", line_rdata); end n_cmp++;
        if (line_raddr !== 32'h0) begin n_err++; $display("FAIL rst_raddr: got %h, expected 0", line_raddr); end n_cmp++;
        if (bmem_read !== 1'b0) begin n_err++; $display("FAIL rst_bread: got %b, expected 0", bmem_read); end n_cmp++;
        if (bmem_write !== 1'b0) begin n_err++; $display("FAIL rst_bwrite: got %b, expected 0", bmem_write); end n_cmp++;
        if (bmem_addr !== 32'h0) begin n_err++; $display("FAIL rst_baddr: got %h, expected 0", bmem_addr); end n_cmp++;
        if (bmem_wdata !== 64'h0) begin n_err++; $display("FAIL rst_bwdata: got %h, expected 0", bmem_wdata); end n_cmp++;
        rst = 1'b1;
        step();
        if (line_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready: got %b, expected 1", line_ready); end n_cmp++;
        last_line = '0;
    endtask

    task automatic test_read();
        logic [63:0]  b [4];
        logic [255:0] exp;
        b[0] = 64'h1111_1111_1111_1111; b[1] = 64'h2222_2222_2222_2222;
        b[2] = 64'h3333_3333_3333_3333; b[3] = 64'h4444_4444_4444_4444;
        exp = {b[3], b[2], b[1], b[0]};
        if (line_ready !== 1'b1) begin n_err++; $display("FAIL rd_idle_ready: got %b, expected 1", line_ready); end n_cmp++;
        line_addr = 32'h1234_5678; line_read = 1'b1;
        step();
        line_read = 1'b0; line_addr = '0;
        if (bmem_read !== 1'b1) begin n_err++; $display("FAIL rd_cmd: got %b, expected 1", bmem_read); end n_cmp++;
        if (bmem_addr !== 32'h1234_5660) begin n_err++; $display("FAIL rd_addr: got %h, expected 12345660", bmem_addr); end n_cmp++;
        if (line_ready !== 1'b0) begin n_err++; $display("FAIL rd_busy_ready: got %b, expected 0", line_ready); end n_cmp++;
        step();
        if (bmem_read !== 1'b0) begin n_err++; $display("FAIL rd_cmd_one_cycle: got %b, expected 0", bmem_read); end n_cmp++;
        for (int i = 0; i < 4; i++) begin
            if (line_resp !== 1'b0) begin n_err++; $display("FAIL rd_early_resp: got %b, expected 0 at beat %0d", line_resp, i); end n_cmp++;
            bmem_rvalid = 1'b1; bmem_raddr = 32'h1234_5660; bmem_rdata = b[i];
            step();
        end
        bmem_rvalid = 1'b0;
        if (line_resp !== 1'b1) begin n_err++; $display("FAIL rd_resp: got %b, expected 1", line_resp); end n_cmp++;
        if (line_rdata !== exp) begin n_err++; $display("FAIL rd_data: got %h, expected %h", line_rdata, exp); end n_cmp++;
        if (line_raddr !== 32'h1234_5660) begin n_err++; $display("FAIL rd_raddr: got %h, expected 12345660", line_raddr); end n_cmp++;
        step();
        if (line_resp !== 1'b0) begin n_err++; $display("FAIL rd_resp_pulse: got %b, expected 0", line_resp); end n_cmp++;
        if (line_ready !== 1'b1) begin n_err++; $display("FAIL rd_ready_back: got %b, expected 1", line_ready); end n_cmp++;
        last_line = exp;
    endtask

    task automatic test_write_backpressure();
        logic [63:0] w [4];
        logic [63:0] acc [8];
        logic        rdy_tbl [6];
        int          idx_tbl [6];
        int          n_acc;
        w[0] = 64'hAAAA_0000_0000_0000; w[1] = 64'hBBBB_0000_0000_0001;
        w[2] = 64'hCCCC_0000_0000_0002; w[3] = 64'hDDDD_0000_0000_0003;
        rdy_tbl = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        idx_tbl = '{0, 1, 1, 1, 2, 3};
        n_acc = 0;
        line_addr = 32'h0000_4010; line_write = 1'b1; line_wdata = {w[3], w[2], w[1], w[0]};
        step();
        line_write = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (bmem_write !== 1'b1) begin n_err++; $display("FAIL wr_strobe: got %b, expected 1 at cycle %0d", bmem_write, k + 1); end n_cmp++;
            if (bmem_wdata !== w[idx_tbl[k]]) begin n_err++; $display("FAIL wr_beat: got %h, expected %h at cycle %0d", bmem_wdata, w[idx_tbl[k]], k + 1); end n_cmp++;
            if (bmem_addr !== 32'h0000_4000) begin n_err++; $display("FAIL wr_addr: got %h, expected 00004000", bmem_addr); end n_cmp++;
            if (bmem_write && rdy_tbl[k] && n_acc < 8) begin
                acc[n_acc] = bmem_wdata;
                n_acc++;
            end
            bmem_ready = rdy_tbl[k];
            step();
        end
        bmem_ready = 1'b1;
        if (line_resp !== 1'b1) begin n_err++; $display("FAIL wr_resp_a7: got %b, expected 1", line_resp); end n_cmp++;
        if (bmem_write !== 1'b0) begin n_err++; $display("FAIL wr_strobe_end: got %b, expected 0", bmem_write); end n_cmp++;
        if (line_raddr !== 32'h0000_4000) begin n_err++; $display("FAIL wr_raddr: got %h, expected 00004000", line_raddr); end n_cmp++;
        if (line_rdata !== last_line) begin n_err++; $display("FAIL wr_rdata_kept: got %h, expected %h", line_rdata, last_line); end n_cmp++;
        if (n_acc !== 4) begin n_err++; $display("FAIL wr_accept_count: got %0d, expected 4", n_acc); end n_cmp++;
        for (int i = 0; i < 4; i++) begin
            if (acc[i] !== w[i]) begin n_err++; $display("FAIL wr_accept_order: got %h, expected %h at %0d", acc[i], w[i], i); end n_cmp++;
        end
        step();
        if (line_ready !== 1'b1) begin n_err++; $display("FAIL wr_ready_back: got %b, expected 1", line_ready); end n_cmp++;
    endtask

    task automatic test_stale_filter();
        logic [31:0]  ra [6];
        logic [63:0]  rd [6];
        logic [255:0] exp;
        ra = '{32'h0000_1000, 32'h0000_2000, 32'h0000_2008, 32'h0000_1000, 32'h0000_201F, 32'h0000_2000};
        rd = '{64'hDEAD_0000_0000_0000, 64'h5000_0000_0000_0000, 64'h5000_0000_0000_0001,
               64'hDEAD_0000_0000_0001, 64'h5000_0000_0000_0002, 64'h5000_0000_0000_0003};
        exp = {rd[5], rd[4], rd[2], rd[1]};
        line_addr = 32'h0000_2000; line_read = 1'b1;
        step();
        line_read = 1'b0;
        // Back-pressure the command while a matching beat shows up early: it must be ignored.
        bmem_ready = 1'b0; bmem_rvalid = 1'b1; bmem_raddr = 32'h0000_2000; bmem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
        step();
        if (bmem_read !== 1'b1) begin n_err++; $display("FAIL sf_cmd_hold: got %b, expected 1", bmem_read); end n_cmp++;
        bmem_ready = 1'b1; bmem_rvalid = 1'b0;
        step();
        if (bmem_read !== 1'b0) begin n_err++; $display("FAIL sf_cmd_done: got %b, expected 0", bmem_read); end n_cmp++;
        for (int i = 0; i < 6; i++) begin
            if (line_resp !== 1'b0) begin n_err++; $display("FAIL sf_early_resp: got %b, expected 0 at step %0d", line_resp, i); end n_cmp++;
            bmem_rvalid = 1'b1; bmem_raddr = ra[i]; bmem_rdata = rd[i];
            step();
        end
        bmem_rvalid = 1'b0;
        if (line_resp !== 1'b1) begin n_err++; $display("FAIL sf_resp: got %b, expected 1", line_resp); end n_cmp++;
        if (line_rdata !== exp) begin n_err++; $display("FAIL sf_data: got %h, expected %h", line_rdata, exp); end n_cmp++;
        if (line_raddr !== 32'h0000_2000) begin n_err++; $display("FAIL sf_raddr: got %h, expected 00002000", line_raddr); end n_cmp++;
        step();
        if (line_resp !== 1'b0) begin n_err++; $display("FAIL sf_resp_pulse: got %b, expected 0", line_resp); end n_cmp++;
        last_line = exp;
    endtask

    task automatic test_simul_rw();
        logic [63:0] s [4];
        for (int i = 0; i < 4; i++) s[i] = 64'h5151_0000_0000_0000 | 64'(i);
        line_addr = 32'h0000_3000; line_read = 1'b1; line_write = 1'b1;
        line_wdata = {s[3], s[2], s[1], s[0]};
        step();
        line_read = 1'b0; line_write = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (bmem_read !== 1'b0) begin n_err++; $display("FAIL rw_no_read: got %b, expected 0", bmem_read); end n_cmp++;
            if (bmem_write !== 1'b1) begin n_err++; $display("FAIL rw_write: got %b, expected 1", bmem_write); end n_cmp++;
            if (bmem_wdata !== s[i]) begin n_err++; $display("FAIL rw_beat: got %h, expected %h", bmem_wdata, s[i]); end n_cmp++;
            step();
        end
        if (line_resp !== 1'b1) begin n_err++; $display("FAIL rw_resp: got %b, expected 1", line_resp); end n_cmp++;
        if (bmem_read !== 1'b0) begin n_err++; $display("FAIL rw_no_read_end: got %b, expected 0", bmem_read); end n_cmp++;
        if (line_rdata !== last_line) begin n_err++; $display("FAIL rw_rdata_kept: got %h, expected %h", line_rdata, last_line); end n_cmp++;
        step();
    endtask

    task automatic test_reset_mid();
        logic [63:0]  g [4];
        logic [255:0] exp;
        for (int i = 0; i < 4; i++) g[i] = 64'h7777_0000_0000_0000 | 64'(i);
        exp = {g[3], g[2], g[1], g[0]};
        line_addr = 32'h0000_4000; line_write = 1'b1; line_wdata = {4{64'hEEEE_EEEE_EEEE_EEEE}};
        step();
        line_write = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (bmem_write !== 1'b1) begin n_err++; $display("FAIL rm_beat_strobe: got %b, expected 1", bmem_write); end n_cmp++;
            step();
        end
        rst = 1'b0;
        step();
        if (bmem_write !== 1'b0) begin n_err++; $display("FAIL rm_write_cleared: got %b, expected 0", bmem_write); end n_cmp++;
        if (line_ready !== 1'b0) begin n_err++; $display("FAIL rm_ready_in_reset: got %b, expected 0", line_ready); end n_cmp++;
        if (line_rdata !== '0) begin n_err++; $display("FAIL rm_rdata_cleared: got %h, expected 0", line_rdata); end n_cmp++;
        if (bmem_addr !== 32'h0) begin n_err++; $display("FAIL rm_addr_cleared: got %h, expected 0", bmem_addr); end n_cmp++;
        rst = 1'b1;
        bmem_rvalid = 1'b1; bmem_raddr = 32'h0000_5000; bmem_rdata = 64'hBADB_AD00_0000_0000;
        step();
        if (line_ready !== 1'b1) begin n_err++; $display("FAIL rm_ready_after: got %b, expected 1", line_ready); end n_cmp++;
        if (line_resp !== 1'b0) begin n_err++; $display("FAIL rm_no_resp: got %b, expected 0", line_resp); end n_cmp++;
        line_addr = 32'h0000_5000; line_read = 1'b1;
        step();
        line_read = 1'b0;
        if (bmem_read !== 1'b1) begin n_err++; $display("FAIL rm_rd_cmd: got %b, expected 1", bmem_read); end n_cmp++;
        bmem_ready = 1'b0; bmem_raddr = 32'h0000_4000; bmem_rdata = 64'hBADB_AD00_0000_0001;
        step();
        bmem_ready = 1'b1; bmem_raddr = 32'h0000_5000; bmem_rdata = 64'hBADB_AD00_0000_0002;
        step();
        for (int i = 0; i < 4; i++) begin
            bmem_rvalid = 1'b1; bmem_raddr = 32'h0000_5000; bmem_rdata = g[i];
            step();
        end
        bmem_rvalid = 1'b0;
        if (line_resp !== 1'b1) begin n_err++; $display("FAIL rm_rd_resp: got %b, expected 1", line_resp); end n_cmp++;
        if (line_rdata !== exp) begin n_err++; $display("FAIL rm_rd_data: got %h, expected %h", line_rdata, exp); end n_cmp++;
        step();
        last_line = exp;
    endtask

    task automatic test_back_to_back();
        logic [63:0]  rb [4];
        logic [63:0]  wb [4];
        logic [255:0] exp;
        int           resp_t [4];
        int           n_resp;
        for (int i = 0; i < 4; i++) begin
            rb[i] = 64'h6666_0000_0000_0000 | 64'(i);
            wb[i] = 64'h9999_0000_0000_0000 | 64'(i);
        end
        exp = {rb[3], rb[2], rb[1], rb[0]};
        n_resp = 0;
        for (int t = 0; t < 16; t++) begin
            if ((line_resp & line_ready) !== 1'b0) begin n_err++; $display("FAIL b2b_resp_in_idle: got resp=%b ready=%b at t=%0d", line_resp, line_ready, t); end n_cmp++;
            if (line_resp === 1'b1 && n_resp < 4) begin
                resp_t[n_resp] = t;
                n_resp++;
            end
            case (t)
                0: begin line_addr = 32'h0000_6000; line_read = 1'b1; end
                1: line_read = 1'b0;
                2, 3, 4, 5: begin
                    bmem_rvalid = 1'b1; bmem_raddr = 32'h0000_6000; bmem_rdata = rb[t-2];
                end
                6: begin
                    bmem_rvalid = 1'b0;
                    if (line_rdata !== exp) begin n_err++; $display("FAIL b2b_rd_data: got %h, expected %h", line_rdata, exp); end n_cmp++;
                end
                7: begin
                    if (line_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_return: got %b, expected 1", line_ready); end n_cmp++;
                    line_addr = 32'h0000_7000; line_write = 1'b1; line_wdata = {wb[3], wb[2], wb[1], wb[0]};
                end
                8, 9, 10, 11: begin
                    line_write = 1'b0;
                    if (bmem_wdata !== wb[t-8]) begin n_err++; $display("FAIL b2b_wr_beat: got %h, expected %h", bmem_wdata, wb[t-8]); end n_cmp++;
                end
                default: ;
            endcase
            step();
        end
        if (n_resp !== 2) begin n_err++; $display("FAIL b2b_resp_count: got %0d, expected 2", n_resp); end n_cmp++;
        if (n_resp == 2) begin
            if (resp_t[0] !== 6) begin n_err++; $display("FAIL b2b_rd_resp_time: got %0d, expected 6", resp_t[0]); end n_cmp++;
            if (resp_t[1] !== 12) begin n_err++; $display("FAIL b2b_wr_resp_time: got %0d, expected 12", resp_t[1]); end n_cmp++;
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_backpressure();
        test_stale_filter();
        test_simul_rw();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
